lcd_spi_writer: RTL



---
 rtl/lcd_spi_writer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/lcd_spi_writer.sv
// lcd_spi_writer
// Sends one 9-bit word (D/C flag + byte) to a SPI LCD panel, mode 0, MSB first.
// A transfer is accepted from IDLE when en_write is high and the post-transfer
// gap has expired. The byte is latched at acceptance, so input changes during
// the transfer are ignored.
//
// Parameters:
//   HALF_DIV   - sys_clk cycles per SCL half-period (1..255)
//   GAP_CYCLES - IDLE cycles after wr_done during which en_write is ignored (0..15)
// Ports:
//   sys_clk   - clock, rising edge
//   sys_rst_n - synchronous active-low reset
//   data      - [8] D/C select, [7:0] byte
//   en_write  - level request to send data
//   wr_done   - one-cycle pulse once the byte has left the pins
//   busy      - high from the cycle after acceptance through the wr_done cycle
//   lcd_cs_n, lcd_dc, lcd_scl, lcd_sdi - panel pins (all registered)
module lcd_spi_writer #(
  parameter int HALF_DIV   = 2,
  parameter int GAP_CYCLES = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [8:0] data,
  input  logic       en_write,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_cs_n,
  output logic       lcd_dc,
  output logic       lcd_scl,
  output logic       lcd_sdi
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [7:0] HALF_LAST = 8'(HALF_DIV - 1);
  localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES);

  state_t     r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic [7:0] r_half;
  logic [3:0] r_gap;
  logic       r_wr_done;
  logic       r_busy;
  logic       r_cs_n;
  logic       r_dc;
  logic       r_scl;
  logic       r_sdi;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit     <= '0;
      r_half    <= '0;
      r_gap     <= '0;
      r_wr_done <= 1'b0;
      r_busy    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_dc      <= 1'b0;
      r_scl     <= 1'b0;
      r_sdi     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_gap != 4'd0) begin
            r_gap <= r_gap - 4'd1;
          end else if (en_write) begin
            r_shift <= data[7:0];
            r_dc    <= data[8];
            r_cs_n  <= 1'b0;
            r_sdi   <= data[7];
            r_scl   <= 1'b0;
            r_busy  <= 1'b1;
            r_bit   <= '0;
            r_half  <= '0;
            r_state <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (r_half == HALF_LAST) begin
            r_half <= '0;
            if (!r_scl) begin
              // end of low phase: rising edge, panel samples SDI here
              r_scl <= 1'b1;
            end else if (r_bit == 3'd7) begin
              // end of the 8th high phase: release the bus
              r_scl     <= 1'b0;
              r_cs_n    <= 1'b1;
              r_sdi     <= 1'b0;
              r_wr_done <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              // falling edge is the only place SDI moves
              r_scl   <= 1'b0;
              r_bit   <= r_bit + 3'd1;
              r_shift <= {r_shift[6:0], 1'b0};
              r_sdi   <= r_shift[6];
            end
          end else begin
            r_half <= r_half + 8'd1;
          end
        end

        S_DONE: begin
          // gap lets the producer update data off its registered wr_done
          r_wr_done <= 1'b0;
          r_busy    <= 1'b0;
          r_gap     <= GAP_LOAD;
          r_state   <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign wr_done  = r_wr_done;
  assign busy     = r_busy;
  assign lcd_cs_n = r_cs_n;
  assign lcd_dc   = r_dc;
  assign lcd_scl  = r_scl;
  assign lcd_sdi  = r_sdi;

endmodule
